// File: rtl/tx_pkg.sv
// tx_pkg: shared types and defaults for the TX frame controller.
//   state_t      - frame FSM state encoding
//   SYM_LEN_DEF  - samples per data symbol (2048 FFT + 512 CP)
//   GAP_CYC_DEF  - idle cycles between frames (must be >= 1)
//   SAMP_W       - sample width {I[31:16],Q[15:0]}
package tx_pkg;

  localparam int SYM_LEN_DEF = 2560;
  localparam int GAP_CYC_DEF = 16;
  localparam int SAMP_W      = 32;
  localparam int SAMP_CNT_W  = 12;
  localparam int SYM_CNT_W   = 8;
  localparam int GAP_CNT_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN,
    ST_DRAIN,
    ST_GAP
  } state_t;

endpackage

// File: rtl/tx_frame_cnt.sv
// tx_frame_cnt: sample/symbol position counter for one frame.
//   clk, rst  - clock, sync active-high reset
//   clr       - restart counting at frame start
//   inc       - one sample accepted
//   nsym      - symbols in this frame (latched by the caller)
//   sym_cnt   - index of the symbol currently being accepted
//   last      - the next accepted sample is the final sample of the frame
module tx_frame_cnt
  import tx_pkg::*;
#(
  parameter int SYM_LEN = SYM_LEN_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 inc,
  input  logic [SYM_CNT_W-1:0] nsym,
  output logic [SYM_CNT_W-1:0] sym_cnt,
  output logic                 last
);

  logic [SAMP_CNT_W-1:0] samp_cnt;
  logic                  samp_wrap;

  assign samp_wrap = (samp_cnt == SAMP_CNT_W'(SYM_LEN - 1));
  assign last      = samp_wrap && (sym_cnt == nsym - SYM_CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      samp_cnt <= '0;
      sym_cnt  <= '0;
    end else if (inc) begin
      if (samp_wrap) begin
        samp_cnt <= '0;
        sym_cnt  <= sym_cnt + SYM_CNT_W'(1);
      end else begin
        samp_cnt <= samp_cnt + SAMP_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/tx_frame_ctrl.sv
// tx_frame_ctrl: frames NSYM symbols of upstream samples onto a downstream
// bus, raising CYC_O one cycle before data (ARM) so the output stage can
// emit its preamble, draining the last sample, then enforcing an idle gap.
//   CLK_I, RST_I              - clock, sync active-high reset
//   DAT_I/CYC_I/STB_I/WE_I    - upstream sample bus; ACK_O accepts (comb)
//   DAT_O/CYC_O/STB_O/WE_O    - downstream sample bus; ACK_I accepts
//   START_I, ABORT_I, NSYM_I  - frame control
//   BUSY_O, DONE_O            - status; DONE_O pulses as the gap ends
//   SYM_IDX_O, FRM_CNT_O      - current symbol index, completed frames
module tx_frame_ctrl
  import tx_pkg::*;
#(
  parameter int SYM_LEN = SYM_LEN_DEF,
  parameter int GAP_CYC = GAP_CYC_DEF
) (
  input  logic                 CLK_I,
  input  logic                 RST_I,
  input  logic [SAMP_W-1:0]    DAT_I,
  input  logic                 CYC_I,
  input  logic                 STB_I,
  input  logic                 WE_I,
  output logic                 ACK_O,
  output logic [SAMP_W-1:0]    DAT_O,
  output logic                 CYC_O,
  output logic                 STB_O,
  output logic                 WE_O,
  input  logic                 ACK_I,
  input  logic                 START_I,
  input  logic                 ABORT_I,
  input  logic [SYM_CNT_W-1:0] NSYM_I,
  output logic                 BUSY_O,
  output logic                 DONE_O,
  output logic [SYM_CNT_W-1:0] SYM_IDX_O,
  output logic [15:0]          FRM_CNT_O
);

  state_t                 state, state_nx;
  logic [SYM_CNT_W-1:0]   nsym;
  logic [GAP_CNT_W-1:0]   gap_cnt;
  logic                   aborted;
  logic                   out_halt;
  logic                   frm_start;
  logic                   gap_done;
  logic                   last;
  logic                   abort_hit;

  assign out_halt  = STB_O & ~ACK_I;
  assign frm_start = (state == ST_IDLE) && START_I && (NSYM_I != '0);
  assign gap_done  = (state == ST_GAP) && (gap_cnt == GAP_CNT_W'(GAP_CYC - 1));
  // An abort that coincides with the final accept loses to it: frame is normal.
  assign abort_hit = ABORT_I && ((state == ST_ARM) ||
                     ((state == ST_RUN) && !(ACK_O && last)));
  assign WE_O      = STB_O;

  tx_frame_cnt #(.SYM_LEN(SYM_LEN)) u_cnt (
    .clk     (CLK_I),
    .rst     (RST_I),
    .clr     (frm_start),
    .inc     (ACK_O),
    .nsym    (nsym),
    .sym_cnt (SYM_IDX_O),
    .last    (last)
  );

  always_ff @(posedge CLK_I) begin
    if (RST_I) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (frm_start) state_nx = ST_ARM;
      ST_ARM:   state_nx = ABORT_I ? ST_DRAIN : ST_RUN;
      ST_RUN:   if ((ACK_O && last) || ABORT_I) state_nx = ST_DRAIN;
      ST_DRAIN: if (!STB_O) state_nx = ST_GAP;
      ST_GAP:   if (gap_done) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    BUSY_O = (state != ST_IDLE);
    // Gated by reset so nothing is accepted in a cycle that is being discarded.
    ACK_O  = CYC_I & STB_I & WE_I & ~out_halt & (state == ST_RUN) & ~RST_I;
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      CYC_O     <= 1'b0;
      STB_O     <= 1'b0;
      DAT_O     <= '0;
      DONE_O    <= 1'b0;
      FRM_CNT_O <= '0;
      nsym      <= '0;
      gap_cnt   <= '0;
      aborted   <= 1'b0;
    end else begin
      // Registered from next state so CYC_O is already high in ARM.
      CYC_O  <= (state_nx == ST_ARM) || (state_nx == ST_RUN) ||
                (state_nx == ST_DRAIN);
      DONE_O <= gap_done;
      if (ACK_O) begin
        DAT_O <= DAT_I;
        STB_O <= 1'b1;
      end else if (!out_halt) begin
        STB_O <= 1'b0;
      end
      if (frm_start) begin
        nsym    <= NSYM_I;
        aborted <= 1'b0;
      end else if (abort_hit) begin
        aborted <= 1'b1;
      end
      gap_cnt <= (state == ST_GAP) ? gap_cnt + GAP_CNT_W'(1) : '0;
      if (gap_done && !aborted) FRM_CNT_O <= FRM_CNT_O + 16'd1;
    end
  end

endmodule

// File: tb/tb_tx_frame_ctrl.sv
module tb_tx_frame_ctrl;

  localparam int SL  = 8;
  localparam int GAP = 16;

  logic        CLK_I = 1'b0;
  logic        RST_I, CYC_I, STB_I, WE_I, ACK_I, START_I, ABORT_I;
  logic [31:0] DAT_I;
  logic [7:0]  NSYM_I;
  logic        ACK_O, CYC_O, STB_O, WE_O, BUSY_O, DONE_O;
  logic [31:0] DAT_O;
  logic [7:0]  SYM_IDX_O;
  logic [15:0] FRM_CNT_O;

  always #5 CLK_I = ~CLK_I;

  tx_frame_ctrl #(.SYM_LEN(SL), .GAP_CYC(GAP)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .DAT_I(DAT_I), .CYC_I(CYC_I), .STB_I(STB_I),
    .WE_I(WE_I), .ACK_O(ACK_O), .DAT_O(DAT_O), .CYC_O(CYC_O), .STB_O(STB_O),
    .WE_O(WE_O), .ACK_I(ACK_I), .START_I(START_I), .ABORT_I(ABORT_I),
    .NSYM_I(NSYM_I), .BUSY_O(BUSY_O), .DONE_O(DONE_O), .SYM_IDX_O(SYM_IDX_O),
    .FRM_CNT_O(FRM_CNT_O)
  );

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Frame-level reference: phase plus counts of accepted samples and gap time.
  typedef enum int {P_IDLE, P_ARM, P_RUN, P_DRAIN, P_GAP} ph_t;
  ph_t         ph;
  int          m_acc, m_total, m_gap;
  bit          m_stb, m_done, m_abt;
  logic [31:0] m_dat;
  logic [15:0] m_frm;
  logic [31:0] sent_q[$];

  // observation monitors
  int cyc_n = 0, fall_t = 0, done_t = 0, done_cnt = 0, ack_obs = 0;
  int low_len = 0, last_low = 0;
  bit cyc_prev = 1'b0;

  task automatic m_reset();
    ph = P_IDLE; m_acc = 0; m_total = 0; m_gap = 0;
    m_stb = 0; m_done = 0; m_abt = 0; m_dat = '0; m_frm = '0;
    sent_q.delete();
  endtask

  task automatic step();
    bit ack_e, halt;
    logic [31:0] exp_d;
    #1;
    halt  = m_stb && !ACK_I;
    ack_e = (ph == P_RUN) && CYC_I && STB_I && WE_I && !halt && !RST_I;
    chk("ack",    ACK_O, ack_e);
    chk("cyc",    CYC_O, (ph == P_ARM) || (ph == P_RUN) || (ph == P_DRAIN));
    chk("stb",    STB_O, m_stb);
    chk("we",     WE_O,  m_stb);
    chk("dat",    DAT_O, m_dat);
    chk("busy",   BUSY_O, ph != P_IDLE);
    chk("done",   DONE_O, m_done);
    chk("symidx", SYM_IDX_O, m_acc / SL);
    chk("frmcnt", FRM_CNT_O, m_frm);
    // downstream handshake must deliver exactly what was accepted upstream
    if (STB_O && ACK_I && !RST_I) begin
      exp_d = (sent_q.size() > 0) ? sent_q.pop_front() : ~DAT_O;
      chk("sb_data", DAT_O, exp_d);
    end
    if (ack_e) sent_q.push_back(DAT_I);
    // monitors on observed outputs
    cyc_n++;
    if (ACK_O) ack_obs++;
    if (DONE_O) begin done_cnt++; done_t = cyc_n; end
    if (cyc_prev && !CYC_O) fall_t = cyc_n;
    if (CYC_O) begin if (low_len != 0) last_low = low_len; low_len = 0; end
    else low_len++;
    cyc_prev = CYC_O;
    // advance reference
    if (RST_I) m_reset();
    else begin
      m_done = 0;
      case (ph)
        P_IDLE: if (START_I && NSYM_I != 0) begin
          ph = P_ARM; m_total = NSYM_I * SL; m_acc = 0; m_abt = 0;
        end
        P_ARM: if (ABORT_I) begin ph = P_DRAIN; m_abt = 1; end else ph = P_RUN;
        P_RUN: begin
          if (ack_e) m_acc++;
          if (ack_e && m_acc == m_total) ph = P_DRAIN;
          else if (ABORT_I) begin ph = P_DRAIN; m_abt = 1; end
        end
        P_DRAIN: if (!m_stb) begin ph = P_GAP; m_gap = 0; end
        P_GAP: begin
          m_gap++;
          if (m_gap == GAP) begin
            ph = P_IDLE; m_done = 1;
            if (!m_abt) m_frm = m_frm + 16'd1;
          end
        end
        default: ph = P_IDLE;
      endcase
      if (ack_e) begin m_dat = DAT_I; m_stb = 1; end
      else if (!halt) m_stb = 0;
    end
    @(negedge CLK_I);
    DAT_I = $urandom;
  endtask

  task automatic start_frame(input int n);
    NSYM_I = 8'(n); START_I = 1; step(); START_I = 0;
  endtask

  task automatic run_until_idle(input int max);
    int k = 0;
    while (ph != P_IDLE && k < max) begin step(); k++; end
    step();
    chk("tmo_idle", BUSY_O, 0);
  endtask

  task automatic run_until_acc(input int n, input int max);
    int k = 0;
    while (m_acc < n && k < max) begin step(); k++; end
    chk("tmo_acc", SYM_IDX_O * SL + 32'(m_acc % SL), n);
  endtask

  logic [31:0] held;
  int a_snap, k;

  initial begin
    RST_I = 1; CYC_I = 0; STB_I = 0; WE_I = 0; ACK_I = 0;
    START_I = 0; ABORT_I = 0; NSYM_I = 0; DAT_I = 0;
    repeat (2) @(negedge CLK_I);
    m_reset();
    step(); step();                     // reset state checked by the model
    RST_I = 0; CYC_I = 1; STB_I = 1; WE_I = 1; ACK_I = 1;

    // basic frame: 2 symbols of 8, full-rate flow
    ack_obs = 0; done_cnt = 0;
    start_frame(2);
    run_until_idle(200);
    chk("s1_acks", ack_obs, 16);
    chk("s1_done_dly", done_t - fall_t, GAP);
    chk("s1_done_cnt", done_cnt, 1);
    chk("s1_frm", FRM_CNT_O, 1);

    // downstream stall of 5 cycles mid-RUN
    ack_obs = 0;
    start_frame(1);
    repeat (3) step();
    ACK_I = 0; held = m_dat;
    repeat (5) begin
      #1;
      chk("halt_ack", ACK_O, 0);
      chk("halt_stb", STB_O, 1);
      chk("halt_dat", DAT_O, held);
      step();
    end
    ACK_I = 1;
    run_until_idle(200);
    chk("s2_acks", ack_obs, 8);
    chk("s2_sb_empty", sent_q.size(), 0);

    // abort after 5 samples
    ack_obs = 0; done_cnt = 0;
    start_frame(1);
    run_until_acc(5, 100);
    ABORT_I = 1; step(); ABORT_I = 0;
    a_snap = ack_obs;
    run_until_idle(200);
    chk("abort_noack", ack_obs, a_snap);
    chk("abort_done", done_cnt, 1);
    chk("abort_frm", FRM_CNT_O, 2);

    // START with NSYM=0 ignored; START during RUN ignored
    start_frame(0);
    repeat (3) step();
    #1 chk("nsym0_busy", BUSY_O, 0);
    ack_obs = 0;
    start_frame(3);
    repeat (5) step();
    NSYM_I = 7; START_I = 1; step(); START_I = 0;
    run_until_idle(400);
    chk("s4_symidx", SYM_IDX_O, 3);
    chk("s4_acks", ack_obs, 24);

    // reset mid-frame, then a full frame
    start_frame(2);
    run_until_acc(3, 50);
    RST_I = 1; step(); RST_I = 0;
    #1;
    chk("rst_cyc", CYC_O, 0);
    chk("rst_stb", STB_O, 0);
    chk("rst_dat", DAT_O, 0);
    chk("rst_frm", FRM_CNT_O, 0);
    chk("rst_busy", BUSY_O, 0);
    chk("rst_ack", ACK_O, 0);
    ack_obs = 0;
    start_frame(1);
    run_until_idle(200);
    chk("s5_acks", ack_obs, 8);
    chk("s5_frm", FRM_CNT_O, 1);

    // START held through GAP: ignored until the first IDLE cycle
    start_frame(1);
    k = 0;
    while (ph != P_GAP && k < 100) begin step(); k++; end
    NSYM_I = 1; START_I = 1;
    k = 0;
    while (ph != P_ARM && k < GAP + 4) begin step(); k++; end
    START_I = 0;
    step();
    chk("gap_low", last_low, GAP + 1);
    run_until_idle(200);
    chk("s6_frm", FRM_CNT_O, 3);

    // randomized frames
    for (int f = 0; f < 40; f++) begin
      repeat ($urandom_range(0, 3)) step();
      CYC_I = 1; STB_I = 1; WE_I = 1;
      start_frame($urandom_range(1, 3));
      k = 0;
      while (ph != P_IDLE && k < 600) begin
        CYC_I   = ($urandom % 10) != 0;
        STB_I   = ($urandom % 5) != 0;
        WE_I    = ($urandom % 20) != 0;
        ACK_I   = ($urandom % 4) != 0;
        ABORT_I = ($urandom % 150) == 0;
        START_I = ($urandom % 30) == 0;
        NSYM_I  = 8'($urandom);
        step(); k++;
      end
      ABORT_I = 0; START_I = 0; ACK_I = 1;
      step();
      chk("rnd_idle", BUSY_O, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
